network_rule_sequencer: RTL and testbench

- Upstream driver and state register for `network_logic`.
- Owns the `current_state` register and generates one rule index per update step. The order is either sequential or LFSR-random.
- Presents each rule for two cycles, because `network_logic` registers the PI3K/PIP3 rules (17, 18). It then commits `next_state`.
- After each round of NUM_RULES steps, it offers the round's final state to the downstream trajectory recorder over a valid/ready handshake.

---
 rtl/dyse_sched_pkg.sv | 26 ++
 rtl/network_rule_sequencer_if.sv | 40 ++++
 rtl/rule_lfsr.sv | 32 +++
 rtl/network_rule_sequencer.sv | 159 +++++++++++++++
 tb/tb_network_rule_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dyse_sched_pkg.sv
// Shared types and constants for the network rule sequencer: FSM encoding,
// default widths tied to the network model, and the rule LFSR definition.
package dyse_sched_pkg;

    localparam int STATE     = 61;
    localparam int LOG_RULES = 6;
    localparam int NUM_RULES_DEFAULT = 38;
    localparam int ROUND_W_DEFAULT   = 10;

    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_COMMIT = 3'd2,
        S_EMIT   = 3'd3,
        S_DONE   = 3'd4
    } sched_state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/network_rule_sequencer_if.sv
// Signal bundle between the rule sequencer, its controller, network_logic and
// the trajectory recorder. state_valid/state_ready: a transfer happens on any
// clock edge where both are high; once state_valid rises it and current_state
// stay unchanged until that transfer.
interface network_rule_sequencer_if
    import dyse_sched_pkg::*;
#(
    parameter int STATE_W = STATE,
    parameter int RULE_W  = LOG_RULES,
    parameter int ROUND_W = ROUND_W_DEFAULT
);
    logic               start;
    logic [ROUND_W-1:0] num_rounds;
    logic               sched_mode;
    logic [15:0]        seed;
    logic [STATE_W-1:0] init_state;
    logic [STATE_W-1:0] next_state;
    logic [RULE_W-1:0]  rule;
    logic [ROUND_W-1:0] round_number;
    logic [STATE_W-1:0] current_state;
    logic               state_valid;
    logic               state_ready;
    logic               busy;
    logic               done;
    sched_state_e       fsm_state;

    modport master (
        input  start, num_rounds, sched_mode, seed, init_state, next_state,
               state_ready,
        output rule, round_number, current_state, state_valid, busy, done,
               fsm_state
    );

    modport slave (
        output start, num_rounds, sched_mode, seed, init_state, next_state,
               state_ready,
        input  rule, round_number, current_state, state_valid, busy, done,
               fsm_state
    );
endinterface

// File: rtl/rule_lfsr.sv
// 16-bit Fibonacci LFSR used as the random rule source. A zero seed would
// lock the register, so it is replaced by the default seed on load.
module rule_lfsr
    import dyse_sched_pkg::*;
#(
    parameter logic [15:0] SEED = SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] value,
    output logic [15:0] next_value,
    output logic [15:0] load_value
);
    logic [15:0] lfsr_q;

    assign load_value = (seed == 16'd0) ? SEED : seed;
    assign next_value = lfsr_step(lfsr_q);
    assign value      = lfsr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else if (load) begin
            lfsr_q <= load_value;
        end else if (advance) begin
            lfsr_q <= next_value;
        end
    end
endmodule

// File: rtl/network_rule_sequencer.sv
// Owns the network state register, issues one rule per step (held two cycles
// so network_logic's registered rules settle), and offers each round's final
// state downstream.
module network_rule_sequencer
    import dyse_sched_pkg::*;
#(
    parameter int          STATE_W   = STATE,
    parameter int          RULE_W    = LOG_RULES,
    parameter int          NUM_RULES = NUM_RULES_DEFAULT,
    parameter int          ROUND_W   = ROUND_W_DEFAULT,
    parameter logic [15:0] SEED      = SEED_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    network_rule_sequencer_if.master bus
);
    localparam logic [RULE_W-1:0] LAST_STEP = RULE_W'(NUM_RULES - 1);
    localparam logic [RULE_W-1:0] RULE_LIM  = RULE_W'(NUM_RULES);

    sched_state_e       state_q, state_d;
    logic [STATE_W-1:0] cur_q, cur_d;
    logic [RULE_W-1:0]  rule_q, rule_d;
    logic [RULE_W-1:0]  step_q, step_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [ROUND_W-1:0] nrounds_q, nrounds_d;
    logic               mode_q, mode_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic        lfsr_load, lfsr_adv;
    logic [15:0] lfsr_value, lfsr_next, lfsr_load_value;

    rule_lfsr #(.SEED(SEED)) u_lfsr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (lfsr_load),
        .advance    (lfsr_adv),
        .seed       (bus.seed),
        .value      (lfsr_value),
        .next_value (lfsr_next),
        .load_value (lfsr_load_value)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            rule_q    <= '0;
            step_q    <= '0;
            round_q   <= '0;
            nrounds_q <= '0;
            mode_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            rule_q    <= rule_d;
            step_q    <= step_d;
            round_q   <= round_d;
            nrounds_q <= nrounds_d;
            mode_q    <= mode_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // rule_q always mirrors the LFSR low bits in random mode, so every LFSR
    // update that leads back into ISSUE also reloads rule_q from the same value.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rule_d    = rule_q;
        step_d    = step_q;
        round_d   = round_q;
        nrounds_d = nrounds_q;
        mode_d    = mode_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    cur_d     = bus.init_state;
                    round_d   = '0;
                    step_d    = '0;
                    nrounds_d = bus.num_rounds;
                    mode_d    = bus.sched_mode;
                    lfsr_load = 1'b1;
                    rule_d    = bus.sched_mode ? lfsr_load_value[RULE_W-1:0] : '0;
                    valid_d   = 1'b0;
                    if (bus.num_rounds == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end

            S_ISSUE: begin
                if (mode_q && (rule_q >= RULE_LIM)) begin
                    lfsr_adv = 1'b1;
                    rule_d   = lfsr_next[RULE_W-1:0];
                end else begin
                    state_d = S_COMMIT;
                end
            end

            S_COMMIT: begin
                cur_d    = bus.next_state;
                step_d   = step_q + RULE_W'(1);
                lfsr_adv = mode_q;
                if (step_q == LAST_STEP) begin
                    state_d = S_EMIT;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                    rule_d  = mode_q ? lfsr_next[RULE_W-1:0] : step_q + RULE_W'(1);
                end
            end

            S_EMIT: begin
                if (bus.state_ready) begin
                    valid_d = 1'b0;
                    round_d = round_q + ROUND_W'(1);
                    step_d  = '0;
                    if (round_q == nrounds_q - ROUND_W'(1)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        rule_d  = mode_q ? lfsr_value[RULE_W-1:0] : '0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rule          = rule_q;
    assign bus.round_number  = round_q;
    assign bus.current_state = cur_q;
    assign bus.state_valid   = valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.fsm_state     = state_q;
endmodule

// File: tb/tb_network_rule_sequencer.sv
// Directed bench for network_rule_sequencer with a stand-in next-state function
// for network_logic and an independent golden model of rules and state.
module tb_network_rule_sequencer;
    import dyse_sched_pkg::*;

    localparam int STATE_W = 61;
    localparam int RULE_W  = 6;
    localparam int NRULES  = 38;
    localparam int ROUND_W = 10;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    logic [RULE_W-1:0] exp_q[$];
    logic [RULE_W-1:0] got_q[$];

    network_rule_sequencer_if #(.STATE_W(STATE_W), .RULE_W(RULE_W), .ROUND_W(ROUND_W)) bus ();

    network_rule_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- network_logic stand-in ----------------
    function automatic logic [STATE_W-1:0] ns_f(input logic [STATE_W-1:0] s, input logic [RULE_W-1:0] r);
        logic [STATE_W-1:0] one;
        one = 61'd1;
        return {s[STATE_W-2:0], s[STATE_W-1]} ^ (one << r) ^ {55'd0, r};
    endfunction

    assign bus.next_state = ns_f(bus.current_state, bus.rule);

    function automatic logic [STATE_W-1:0] golden_seq(input logic [STATE_W-1:0] init, input int rounds);
        logic [STATE_W-1:0] s;
        s = init;
        for (int rr = 0; rr < rounds; rr++)
            for (int r = 0; r < NRULES; r++)
                s = ns_f(s, RULE_W'(r));
        return s;
    endfunction

    function automatic logic [15:0] lfsr_model(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [ROUND_W-1:0] nr, input logic mode,
                            input logic [15:0] sd, input logic [STATE_W-1:0] init);
        bus.num_rounds = nr;
        bus.sched_mode = mode;
        bus.seed       = sd;
        bus.init_state = init;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    // Returns on the negedge where state_valid is first seen; cyc counts
    // cycles from the start edge (first ISSUE cycle is 1).
    task automatic wait_emit(output int cyc, output int hold_err);
        sched_state_e      prev_st;
        logic [RULE_W-1:0] prev_rule;
        got_q.delete();
        cyc = 1;
        hold_err = 0;
        prev_st = S_IDLE;
        prev_rule = '0;
        while (!bus.state_valid && cyc < 3000) begin
            if (bus.fsm_state == S_COMMIT) begin
                got_q.push_back(bus.rule);
                if (prev_st != S_ISSUE || prev_rule != bus.rule) hold_err++;
            end
            prev_st = bus.fsm_state;
            prev_rule = bus.rule;
            @(negedge clk);
            cyc++;
        end
        if (!bus.state_valid) check("emit_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_rules(input string tag);
        int n;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_rule%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic load_seq_rules();
        exp_q.delete();
        for (int r = 0; r < NRULES; r++) exp_q.push_back(RULE_W'(r));
    endtask

    // ---------------- tests ----------------
    initial begin
        int cyc, herr, rej, chg;
        logic [STATE_W-1:0] init_a, init_b, s, hold_state;
        logic [15:0] ls;
        logic [RULE_W-1:0] mx;

        n_tests = 0;
        n_fail  = 0;
        init_a  = 61'h0123_4567_89AB_CDE;
        init_b  = 61'h1A5A_F00D_0BAD_C0F;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.num_rounds = '0;
        bus.sched_mode = 1'b0;
        bus.seed = '0;
        bus.init_state = '0;
        bus.state_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_state", 64'(bus.current_state), 64'd0);
        check("rst_rule", 64'(bus.rule), 64'd0);
        check("rst_round", 64'(bus.round_number), 64'd0);
        check("rst_flags", {61'd0, bus.state_valid, bus.busy, bus.done}, 64'd0);
        check("rst_fsm", 64'(bus.fsm_state), 64'(S_IDLE));

        // sequential, one round, no backpressure
        do_start(10'd1, 1'b0, 16'd0, init_a);
        wait_emit(cyc, herr);
        load_seq_rules();
        check_rules("seq1");
        check("seq1_latency", 64'(cyc), 64'd77);
        check("seq1_hold", 64'(herr), 64'd0);
        check("seq1_state", 64'(bus.current_state), 64'(golden_seq(init_a, 1)));
        check("seq1_busy", 64'(bus.busy), 64'd1);
        check("seq1_emit_round", 64'(bus.round_number), 64'd0);
        @(negedge clk);
        check("seq1_done", {61'd0, bus.done, bus.busy, bus.state_valid}, 64'b100);
        check("seq1_done_round", 64'(bus.round_number), 64'd1);

        // backpressure for 10 cycles at the first emit of a 2-round run
        bus.state_ready = 1'b0;
        do_start(10'd2, 1'b0, 16'd0, init_b);
        wait_emit(cyc, herr);
        hold_state = bus.current_state;
        chg = 0;
        repeat (10) begin
            @(negedge clk);
            if (!bus.state_valid || bus.current_state != hold_state ||
                bus.round_number != 10'd0 || bus.rule != RULE_W'(NRULES - 1)) chg++;
        end
        check("bp_stable", 64'(chg), 64'd0);
        check("bp_state", 64'(hold_state), 64'(golden_seq(init_b, 1)));
        bus.state_ready = 1'b1;
        @(negedge clk);
        check("bp_round_inc", 64'(bus.round_number), 64'd1);
        check("bp_valid_drop", 64'(bus.state_valid), 64'd0);
        check("bp_fsm_issue", 64'(bus.fsm_state), 64'(S_ISSUE));
        wait_emit(cyc, herr);
        check("bp_r2_state", 64'(bus.current_state), 64'(golden_seq(init_b, 2)));
        check("bp_r2_round", 64'(bus.round_number), 64'd1);
        @(negedge clk);
        check("bp_done_round", 64'(bus.round_number), 64'd2);
        check("bp_done", 64'(bus.done), 64'd1);

        // num_rounds = 0
        do_start(10'd0, 1'b0, 16'd0, init_a);
        check("nr0_fsm", 64'(bus.fsm_state), 64'(S_DONE));
        check("nr0_flags", {61'd0, bus.done, bus.busy, bus.state_valid}, 64'b100);
        check("nr0_state", 64'(bus.current_state), 64'(init_a));
        @(negedge clk);
        check("nr0_valid_later", 64'(bus.state_valid), 64'd0);

        // random mode, seed 0 behaves as ACE1
        exp_q.delete();
        ls = 16'hACE1;
        rej = 0;
        while (exp_q.size() < NRULES) begin
            if (ls[5:0] >= 6'(NRULES)) rej++;
            else exp_q.push_back(ls[5:0]);
            ls = lfsr_model(ls);
        end
        do_start(10'd1, 1'b1, 16'd0, init_a);
        wait_emit(cyc, herr);
        check_rules("rnd");
        check("rnd_latency", 64'(cyc), 64'(77 + rej));
        check("rnd_hold", 64'(herr), 64'd0);
        mx = '0;
        foreach (got_q[i]) if (got_q[i] > mx) mx = got_q[i];
        check("rnd_max_lt38", 64'(mx < 6'(NRULES)), 64'd1);
        s = init_a;
        foreach (exp_q[i]) s = ns_f(s, exp_q[i]);
        check("rnd_state", 64'(bus.current_state), 64'(s));
        @(negedge clk);
        check("rnd_done", 64'(bus.done), 64'd1);

        // three rounds
        do_start(10'd3, 1'b0, 16'd0, init_b);
        for (int r = 0; r < 3; r++) begin
            wait_emit(cyc, herr);
            check($sformatf("r3_emit_round%0d", r), 64'(bus.round_number), 64'(r));
            check($sformatf("r3_state%0d", r), 64'(bus.current_state), 64'(golden_seq(init_b, r + 1)));
            @(negedge clk);
        end
        check("r3_done_round", 64'(bus.round_number), 64'd3);
        check("r3_done", {61'd0, bus.done, bus.busy, bus.state_valid}, 64'b100);

        // reset during COMMIT of round 1
        do_start(10'd2, 1'b0, 16'd0, init_a);
        cyc = 0;
        while (!(bus.round_number == 10'd1 && bus.fsm_state == S_COMMIT) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_reached", 64'(bus.fsm_state == S_COMMIT && bus.round_number == 10'd1), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rstm_state", 64'(bus.current_state), 64'd0);
        check("rstm_rule_round", {48'd0, 6'(bus.rule), bus.round_number}, 64'd0);
        check("rstm_flags", {61'd0, bus.state_valid, bus.busy, bus.done}, 64'd0);
        check("rstm_fsm", 64'(bus.fsm_state), 64'(S_IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_start(10'd1, 1'b0, 16'd0, init_a);
        wait_emit(cyc, herr);
        check("rerun_latency", 64'(cyc), 64'd77);
        check("rerun_state", 64'(bus.current_state), 64'(golden_seq(init_a, 1)));
        @(negedge clk);
        check("rerun_done", 64'(bus.done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
